idct2d_stream: RTL and testbench

IDCT2D_STREAM -- requirements
Module: idct2d_stream

---
 rtl/idct2d_stream.sv | 188 ++++++++++++++++++
 tb/tb_idct2d_stream.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idct2d_stream.sv
// idct2d_stream: 8x8 2-D IDCT, one coefficient row in and one pixel
// column out per beat, through a ping-pong transpose buffer.
module idct2d_stream #(
   parameter int IN_W  = 12,
   parameter int MID_W = 11,
   parameter int OUT_W = 8,
   parameter int CNT_W = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [8*IN_W-1:0]    data_in,
   input  logic                 mode_bypass,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [8*OUT_W-1:0]   data_out,
   output logic                 out_last,
   output logic [CNT_W-1:0]     cnt_out
);

   typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_st_e;

   // c(u)/2 * cos((2x+1)u*pi/16) scaled by 2^11
   function automatic int coef(int x, int u);
      int k;
      int m;
      int mag;
      if (u == 0) return 724;
      k = ((2 * x + 1) * u) % 32;
      if (k <= 8) m = k;
      else if (k <= 16) m = 16 - k;
      else if (k <= 24) m = k - 16;
      else m = 32 - k;
      case (m)
         0: mag = 1024;
         1: mag = 1004;
         2: mag = 946;
         3: mag = 851;
         4: mag = 724;
         5: mag = 569;
         6: mag = 392;
         7: mag = 200;
         default: mag = 0;
      endcase
      return (k > 8 && k < 24) ? -mag : mag;
   endfunction

   function automatic logic signed [MID_W-1:0] sat_mid(int v);
      int hi;
      hi = (1 << (MID_W - 1)) - 1;
      if (v > hi) v = hi;
      else if (v < -hi - 1) v = -hi - 1;
      return MID_W'(v);
   endfunction

   function automatic logic [OUT_W-1:0] clamp_px(int v);
      int hi;
      hi = (1 << OUT_W) - 1;
      if (v > hi) v = hi;
      else if (v < 0) v = 0;
      return OUT_W'(v);
   endfunction

   bank_st_e                st_q [2];
   bank_st_e                st_d [2];
   logic [1:0]              mode_q, mode_d;
   logic                    wr_bank_q, wr_bank_d;
   logic                    rd_bank_q, rd_bank_d;
   logic [2:0]              wr_ptr_q, wr_ptr_d;
   logic [2:0]              rd_ptr_q, rd_ptr_d;
   logic                    vld_q, vld_d;
   logic                    last_q, last_d;
   logic [8*OUT_W-1:0]      dout_q, dout_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic signed [MID_W-1:0] bank_q [2][8][8];
   logic signed [MID_W-1:0] row_mid [8];
   logic [8*OUT_W-1:0]      col_px;
   logic                    row_byp, col_byp, wr_en, rd_en;
   int                      rin [8];
   int                      cin [8];
   int                      racc, cacc;

   assign in_ready  = (st_q[wr_bank_q] != FULL);
   assign wr_en     = in_valid && in_ready;
   assign rd_en     = (st_q[rd_bank_q] == FULL) && (!vld_q || out_ready);
   // row 0 carries the block mode; later rows reuse the stored bit
   assign row_byp   = (wr_ptr_q == 3'd0) ? mode_bypass : mode_q[wr_bank_q];
   assign col_byp   = mode_q[rd_bank_q];
   assign out_valid = vld_q;
   assign out_last  = last_q;
   assign data_out  = dout_q;
   assign cnt_out   = cnt_q;

   always_comb begin
      racc = 0;
      for (int k = 0; k < 8; k++) rin[k] = int'($signed(data_in[k*IN_W +: IN_W]));
      for (int x = 0; x < 8; x++) begin
         racc = 0;
         for (int u = 0; u < 8; u++) racc = racc + coef(x, u) * rin[u];
         racc = (racc + 1024) >>> 11;
         row_mid[x] = sat_mid(row_byp ? rin[x] : racc);
      end
   end

   always_comb begin
      cacc   = 0;
      col_px = '0;
      for (int r = 0; r < 8; r++) cin[r] = int'(bank_q[rd_bank_q][r][rd_ptr_q]);
      for (int y = 0; y < 8; y++) begin
         cacc = 0;
         for (int v = 0; v < 8; v++) cacc = cacc + coef(y, v) * cin[v];
         cacc = ((cacc + 1024) >>> 11) + 128;
         col_px[y*OUT_W +: OUT_W] = clamp_px(col_byp ? cin[y] : cacc);
      end
   end

   always_comb begin
      st_d      = st_q;
      mode_d    = mode_q;
      wr_bank_d = wr_bank_q;
      wr_ptr_d  = wr_ptr_q;
      rd_bank_d = rd_bank_q;
      rd_ptr_d  = rd_ptr_q;
      vld_d     = vld_q;
      last_d    = last_q;
      dout_d    = dout_q;
      cnt_d     = cnt_q;
      if (wr_en) begin
         if (wr_ptr_q == 3'd0) mode_d[wr_bank_q] = mode_bypass;
         wr_ptr_d = wr_ptr_q + 3'd1;
         st_d[wr_bank_q] = FILLING;
         if (wr_ptr_q == 3'd7) begin
            st_d[wr_bank_q] = FULL;
            wr_bank_d = ~wr_bank_q;
         end
      end
      if (vld_q && out_ready) begin
         vld_d  = 1'b0;
         last_d = 1'b0;
         cnt_d  = cnt_q + 1'b1;
      end
      if (rd_en) begin
         vld_d    = 1'b1;
         last_d   = (rd_ptr_q == 3'd7);
         dout_d   = col_px;
         rd_ptr_d = rd_ptr_q + 3'd1;
         if (rd_ptr_q == 3'd7) begin
            st_d[rd_bank_q] = EMPTY;
            rd_bank_d = ~rd_bank_q;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_q[0]   <= EMPTY;
         st_q[1]   <= EMPTY;
         mode_q    <= '0;
         wr_bank_q <= 1'b0;
         wr_ptr_q  <= '0;
         rd_bank_q <= 1'b0;
         rd_ptr_q  <= '0;
         vld_q     <= 1'b0;
         last_q    <= 1'b0;
         dout_q    <= '0;
         cnt_q     <= '0;
      end else begin
         st_q      <= st_d;
         mode_q    <= mode_d;
         wr_bank_q <= wr_bank_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_bank_q <= rd_bank_d;
         rd_ptr_q  <= rd_ptr_d;
         vld_q     <= vld_d;
         last_q    <= last_d;
         dout_q    <= dout_d;
         cnt_q     <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int k = 0; k < 8; k++) bank_q[wr_bank_q][wr_ptr_q][k] <= row_mid[k];
      end
   end

endmodule

// File: tb/tb_idct2d_stream.sv
// Bench for idct2d_stream: real-valued 2-D IDCT reference and
// scoreboard, plus directed block sequences.
module tb_idct2d_stream;

   localparam int IN_W  = 12;
   localparam int MID_W = 11;
   localparam int OUT_W = 8;
   localparam int CNT_W = 15;

   logic                clk         = 1'b0;
   logic                reset       = 1'b0;
   logic                in_valid    = 1'b0;
   logic                in_ready;
   logic [8*IN_W-1:0]   data_in     = '0;
   logic                mode_bypass = 1'b0;
   logic                out_valid;
   logic                out_ready   = 1'b1;
   logic [8*OUT_W-1:0]  data_out;
   logic                out_last;
   logic [CNT_W-1:0]    cnt_out;

   int checks  = 0;
   int errors  = 0;
   int exp_cnt = 0;
   bit rr_en       = 0;
   bit ready_force = 1;
   bit gaps        = 0;
   int blk [8][8];

   typedef struct packed {
      logic [8*OUT_W-1:0] px;
      logic               last;
      logic               tol;
   } exp_t;
   exp_t exp_q [$];

   typedef struct {
      int val;
      int exp;
   } vec_t;
   vec_t tbl [8];

   idct2d_stream #(
      .IN_W(IN_W), .MID_W(MID_W), .OUT_W(OUT_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .data_in(data_in),
      .mode_bypass(mode_bypass),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .data_out(data_out),
      .out_last(out_last),
      .cnt_out(cnt_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      out_ready = rr_en ? ($urandom_range(0, 3) != 0) : ready_force;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   function automatic int sat_mid(int v);
      if (v > 1023) return 1023;
      if (v < -1024) return -1024;
      return v;
   endfunction

   function automatic int clamp_px(int v);
      if (v > 255) return 255;
      if (v < 0) return 0;
      return v;
   endfunction

   function automatic int ref_px(int r, int c, bit byp);
      real s, pi, cv, cu;
      if (byp) return clamp_px(sat_mid(blk[r][c]));
      pi = 3.14159265358979;
      s = 0.0;
      for (int v = 0; v < 8; v++) begin
         for (int u = 0; u < 8; u++) begin
            cv = (v == 0) ? 0.35355339059 : 0.5;
            cu = (u == 0) ? 0.35355339059 : 0.5;
            s = s + cv * $cos((2 * r + 1) * v * pi / 16.0)
                  * cu * $cos((2 * c + 1) * u * pi / 16.0) * blk[v][u];
         end
      end
      return clamp_px($rtoi(s + ((s >= 0.0) ? 0.5 : -0.5)) + 128);
   endfunction

   function automatic void push_expected(bit byp);
      exp_t e;
      for (int c = 0; c < 8; c++) begin
         e.px = '0;
         for (int r = 0; r < 8; r++) e.px[r*OUT_W +: OUT_W] = OUT_W'(ref_px(r, c, byp));
         e.last = (c == 7);
         e.tol  = !byp;
         exp_q.push_back(e);
         exp_cnt++;
      end
   endfunction

   function automatic logic [8*IN_W-1:0] pack_row(int r);
      logic [8*IN_W-1:0] v;
      v = '0;
      for (int c = 0; c < 8; c++) v[c*IN_W +: IN_W] = IN_W'(blk[r][c]);
      return v;
   endfunction

   function automatic void fill_rand(bit byp);
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            blk[r][c] = byp ? int'($urandom_range(0, 4095)) - 2048
                            : int'($urandom_range(0, 200)) - 100;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_row(logic [8*IN_W-1:0] d, bit byp);
      int n;
      if (gaps) begin
         n = $urandom_range(0, 2);
         if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
         end
      end
      in_valid    = 1'b1;
      data_in     = d;
      mode_bypass = byp;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 500) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL in_ready_timeout: got 0 expected 1");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_block(bit byp0, int tog, bit model);
      if (model) push_expected(byp0);
      for (int r = 0; r < 8; r++) send_row(pack_row(r), (r == tog) ? !byp0 : byp0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      repeat (3) @(posedge clk);
      #2;
   endtask

   exp_t        me;
   logic        hold_v = 1'b0;
   logic [63:0] hold_d;
   logic        hold_l;
   bit          mok;
   int          md, mt;

   always @(negedge clk) begin
      if (!reset) hold_v = 1'b0;
      else begin
         if (hold_v) begin
            checks++;
            if (!out_valid || data_out !== hold_d || out_last !== hold_l) begin
               errors++;
               $display("FAIL hold: got v=%0b d=%0h expected d=%0h", out_valid, data_out, hold_d);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL beat: got %0h expected no beat", data_out);
            end else begin
               me  = exp_q.pop_front();
               mok = (out_last === me.last);
               mt  = me.tol ? 2 : 0;
               for (int r = 0; r < 8; r++) begin
                  md = int'(data_out[r*OUT_W +: OUT_W]) - int'(me.px[r*OUT_W +: OUT_W]);
                  if (md > mt || md < -mt) mok = 0;
               end
               if (!mok) begin
                  errors++;
                  $display("FAIL beat: got %0h last %0b expected %0h last %0b",
                           data_out, out_last, me.px, me.last);
               end
            end
         end
         hold_v = out_valid && !out_ready;
         hold_d = data_out;
         hold_l = out_last;
      end
   end

   initial begin
      exp_t e;
      logic [63:0] col0;

      tbl[0] = '{-2048, 0};
      tbl[1] = '{2047, 255};
      tbl[2] = '{300, 255};
      tbl[3] = '{-1, 0};
      tbl[4] = '{0, 0};
      tbl[5] = '{255, 255};
      tbl[6] = '{256, 255};
      tbl[7] = '{-1024, 0};

      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", out_valid, 0);
      check("rst_last", out_last, 0);
      check("rst_data", data_out, 0);
      check("rst_cnt", cnt_out, 0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #2;
      check("rst_in_ready", in_ready, 1);

      // bypass transpose with latency probe
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) blk[r][c] = 8 * r + c;
      push_expected(1'b1);
      for (int r = 0; r < 8; r++) send_row(pack_row(r), 1'b1);
      check("lat_e", out_valid, 0);
      @(posedge clk);
      #1;
      check("lat_e1_valid", out_valid, 1);
      col0 = '0;
      for (int r = 0; r < 8; r++) col0[r*OUT_W +: OUT_W] = OUT_W'(8 * r);
      check("lat_e1_col0", data_out, col0);
      drain();
      check("transpose_cnt", cnt_out, 8);

      // saturation table: row r holds tbl[r].val in every element
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) blk[r][c] = tbl[r].val;
      for (int c = 0; c < 8; c++) begin
         e.px = '0;
         for (int r = 0; r < 8; r++) e.px[r*OUT_W +: OUT_W] = OUT_W'(tbl[r].exp);
         e.last = (c == 7);
         e.tol  = 1'b0;
         exp_q.push_back(e);
         exp_cnt++;
      end
      send_block(1'b1, -1, 1'b0);
      drain();

      // all-zero transform block is flat mid-grey
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) blk[r][c] = 0;
      for (int c = 0; c < 8; c++) begin
         e.px   = {8{8'd128}};
         e.last = (c == 7);
         e.tol  = 1'b0;
         exp_q.push_back(e);
         exp_cnt++;
      end
      send_block(1'b0, -1, 1'b0);
      drain();
      check("dc_cnt", cnt_out, exp_cnt);

      // backpressure: two blocks fill both banks with out_ready low
      ready_force = 0;
      @(posedge clk);
      #2;
      fill_rand(1'b1);
      send_block(1'b1, -1, 1'b1);
      fill_rand(1'b1);
      send_block(1'b1, -1, 1'b1);
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      repeat (4) @(posedge clk);
      #2;
      ready_force = 1;
      fill_rand(1'b1);
      send_block(1'b1, -1, 1'b1);
      drain();
      check("bp_cnt", cnt_out, exp_cnt);

      // mode switch: bypass block then transform block, mode flips on row 3
      fill_rand(1'b0);
      send_block(1'b1, -1, 1'b1);
      fill_rand(1'b0);
      send_block(1'b0, 3, 1'b1);
      drain();
      check("mode_cnt", cnt_out, exp_cnt);

      // randomized blocks with random out_ready and input gaps
      rr_en = 1;
      gaps  = 1;
      for (int b = 0; b < 10; b++) begin
         bit byp;
         byp = ($urandom_range(0, 1) == 1);
         fill_rand(byp);
         send_block(byp, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 7)) : -1, 1'b1);
      end
      drain();
      rr_en = 0;
      gaps  = 0;
      check("rand_cnt", cnt_out, exp_cnt);

      // reset after five rows of a block
      ready_force = 1;
      @(posedge clk);
      #2;
      fill_rand(1'b1);
      for (int r = 0; r < 5; r++) send_row(pack_row(r), 1'b1);
      reset = 1'b0;
      #2;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_cnt", cnt_out, 0);
      check("mid_rst_data", data_out, 0);
      exp_q.delete();
      exp_cnt = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #2;
      check("mid_rst_in_ready", in_ready, 1);
      fill_rand(1'b1);
      send_block(1'b1, -1, 1'b1);
      drain();
      check("mid_rst_final_cnt", cnt_out, 8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
